// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Holds state encoding, requester count, pointer width and a one-hot decode helper.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int PTR_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Pointer-ordered request selection: returns the first set request starting at ptr,
// scanning upward mod 4, as a one-hot pick plus an any-request flag.
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl_req;
    logic [2*NUM_REQ-1:0] dbl_pick;
    logic [NUM_REQ-1:0]   rot_req;
    logic [NUM_REQ-1:0]   rot_pick;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        dbl_req  = {req, req} >> ptr;
        rot_req  = dbl_req[NUM_REQ-1:0];
        rot_pick = rot_req & (~rot_req + 4'd1);
        dbl_pick = {rot_pick, rot_pick} << ptr;
        pick     = dbl_pick[2*NUM_REQ-1:NUM_REQ];
        any      = |req;
    end

endmodule

// File: rtl/round_robin_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant, hold timeout
// and a guaranteed one-cycle idle bubble between grants.
//
// state | meaning
// IDLE  | no grant held; arbitrate pending requests from PTR
// BUSY  | one grant held; release on DONE, owner drop or hold timeout
module round_robin_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic R0,
    input  logic R1,
    input  logic R2,
    input  logic R3,
    input  logic DONE,
    output logic G0,
    output logic G1,
    output logic G2,
    output logic G3,
    output logic VALID
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               valid_q, valid_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [7:0]         hold_q, hold_d;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] pick;
    logic               any_req;
    logic               release_now;

    assign req = {R3, R2, R1, R0};

    rr_pick_4 u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any_req)
    );

    assign release_now = DONE || !req[owner_q] || (hold_q == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            owner_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    grant_d = pick;
                    valid_d = 1'b1;
                    owner_d = onehot_to_idx(pick);
                    hold_d  = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = owner_q + 2'd1;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign G0    = grant_q[0];
    assign G1    = grant_q[1];
    assign G2    = grant_q[2];
    assign G3    = grant_q[3];
    assign VALID = valid_q;

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Self-checking bench for round_robin_arbiter_4: vector table, hand-written corner
// sequences and randomized traffic against a behavioural arbitration model.
module tb_round_robin_arbiter_4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       G0, G1, G2, G3, VALID;
    logic [3:0] g;

    int n_cmp = 0;
    int n_bad = 0;

    int m_owner;
    int m_ptr;
    int m_hold;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] exp_g;
    } vec_t;

    vec_t vecs[23];

    always #5 clk = ~clk;

    assign g = {G3, G2, G1, G0};

    round_robin_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .R0    (req[0]),
        .R1    (req[1]),
        .R2    (req[2]),
        .R3    (req[3]),
        .DONE  (done),
        .G0    (G0),
        .G1    (G1),
        .G2    (G2),
        .G3    (G3),
        .VALID (VALID)
    );

    // Downstream 4-to-2 encoder fed by the grant lines.
    function automatic logic [1:0] enc(input logic [3:0] oh);
        logic [1:0] y;
        y = 2'd0;
        if (oh[1]) y = 2'd1;
        if (oh[2]) y = 2'd2;
        if (oh[3]) y = 2'd3;
        return y;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_cmp++;
        if ($countones(g) > 1) begin
            n_bad++;
            $display("FAIL onehot: got %b expected at most one bit at %0t", g, $time);
        end
        chk("valid_vs_grant", {31'd0, VALID}, {31'd0, (g != 4'b0)});
    endtask

    task automatic check_grant(input string name, input logic [3:0] exp);
        chk(name, {28'd0, g}, {28'd0, exp});
        if (exp != 4'b0) chk({name, "_enc"}, {30'd0, enc(g)}, {30'd0, enc(exp)});
    endtask

    // Reference: owner index or -1, cycles granted so far, rotating priority start.
    task automatic model_step(input logic [3:0] r, input logic d);
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx;
                    m_hold  = 1;
                end
            end
        end else if (d || !r[m_owner] || m_hold == MAX_HOLD) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end else begin
            m_hold++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    initial begin
        int cnt;
        logic [3:0] exp;

        vecs[0]  = '{4'b1111, 1'b0, 4'b0001};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0000};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0010};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0000};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0100};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0000};
        vecs[6]  = '{4'b1111, 1'b0, 4'b1000};
        vecs[7]  = '{4'b1111, 1'b1, 4'b0000};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0001};
        vecs[9]  = '{4'b1111, 1'b1, 4'b0000};
        vecs[10] = '{4'b1010, 1'b0, 4'b0010};
        vecs[11] = '{4'b1000, 1'b0, 4'b0000};
        vecs[12] = '{4'b1000, 1'b0, 4'b1000};
        vecs[13] = '{4'b1000, 1'b1, 4'b0000};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000};
        vecs[16] = '{4'b0100, 1'b0, 4'b0100};
        vecs[17] = '{4'b0101, 1'b0, 4'b0100};
        vecs[18] = '{4'b0001, 1'b0, 4'b0000};
        vecs[19] = '{4'b0011, 1'b0, 4'b0001};
        vecs[20] = '{4'b0011, 1'b1, 4'b0000};
        vecs[21] = '{4'b0011, 1'b0, 4'b0010};
        vecs[22] = '{4'b0000, 1'b0, 4'b0000};

        // Reset with all requests high: nothing granted until reset releases.
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        #1;
        check_grant("reset_async", 4'b0000);
        chk("reset_valid", {31'd0, VALID}, 32'd0);
        tick();
        check_grant("reset_held", 4'b0000);
        rst_n = 1'b1;

        // Vector table: rotation, request drop, DONE in IDLE, non-owner changes.
        for (int i = 0; i < 23; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            tick();
            check_grant($sformatf("vec%0d", i), vecs[i].exp_g);
        end

        // Timeout: R2 alone held for MAX_HOLD cycles then re-granted after bubble.
        req  = 4'b0100;
        done = 1'b0;
        tick();
        cnt = 0;
        while (g == 4'b0100 && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("timeout_len", cnt, MAX_HOLD);
        check_grant("timeout_bubble", 4'b0000);
        tick();
        check_grant("timeout_regrant", 4'b0100);
        req = 4'b0000;
        tick();
        check_grant("timeout_release", 4'b0000);

        // Mid-grant reset: grant drops without a clock edge, restart from PTR=0.
        req = 4'b0100;
        tick();
        check_grant("midrst_grant", 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check_grant("midrst_drop", 4'b0000);
        chk("midrst_valid", {31'd0, VALID}, 32'd0);
        req = 4'b0101;
        tick();
        check_grant("midrst_held", 4'b0000);
        rst_n = 1'b1;
        tick();
        check_grant("midrst_first", 4'b0001);

        // Randomized traffic against the reference model.
        req  = 4'b0000;
        done = 1'b0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 7) == 0);
            tick();
            model_step(req, done);
            exp = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            check_grant("random", exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
